// File: rtl/fpga_ps_loader.sv
// Passive-serial configuration sequencer: streams host bytes LSB first onto DCLK/DATA0,
// watches nSTATUS / CONF_DONE / INIT_DONE and finishes with a warm-reset pulse.
module fpga_ps_loader #(
  parameter int NCFG_CYC   = 64,
  parameter int DCLK_HALF  = 2,
  parameter int TMO_CYC    = 65535,
  parameter int EXTRA_DCLK = 10,
  parameter int WRES_CYC   = 16
) (
  input  logic       clkin,
  input  logic       coldres_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       config_n,
  output logic       dclk,
  output logic       data0,
  input  logic       status_n,
  input  logic       conf_done,
  input  logic       init_done,
  output logic       warmres_n,
  output logic       busy,
  output logic       done,
  output logic [1:0] error,
  output logic [3:0] state_dbg
);

  // Handshake: a byte moves on a rising clkin edge where data_valid and data_ready are
  // both high; data_ready is high only in LOAD, data_in must be stable while data_valid is high.

  typedef enum logic [3:0] {
    S_IDLE, S_NCFG, S_WAIT_STATUS, S_LOAD, S_SHIFT,
    S_EXTRA, S_WAIT_INIT, S_WRES, S_DONE, S_ERROR
  } state_t;

  localparam int CNT_MAX_A = (NCFG_CYC > TMO_CYC) ? NCFG_CYC : TMO_CYC;
  localparam int CNT_MAX_B = (WRES_CYC > DCLK_HALF) ? WRES_CYC : DCLK_HALF;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PUL_MAX   = (EXTRA_DCLK > 1) ? EXTRA_DCLK : 1;
  localparam int PUL_W     = $clog2(PUL_MAX + 1);

  localparam logic [CNT_W-1:0] NCFG_LAST = CNT_W'(NCFG_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DCLK_HALF - 1);
  localparam logic [CNT_W-1:0] WRES_LAST = CNT_W'(WRES_CYC - 1);
  localparam logic [PUL_W-1:0] PUL_LAST  = PUL_W'(PUL_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PUL_W-1:0] pul_q, pul_d;
  logic [2:0]       bit_q, bit_d;
  logic             hi_q, hi_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             dclk_d, data0_d, config_n_d, data_ready_d, warmres_n_d, busy_d, done_d;
  logic [1:0]       error_d;
  logic             half_end;

  assign state_dbg = state_q;

  always_ff @(posedge clkin) begin
    if (!coldres_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pul_q      <= '0;
      bit_q      <= '0;
      hi_q       <= 1'b0;
      shreg_q    <= '0;
      config_n   <= 1'b1;
      dclk       <= 1'b0;
      data0      <= 1'b0;
      data_ready <= 1'b0;
      warmres_n  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pul_q      <= pul_d;
      bit_q      <= bit_d;
      hi_q       <= hi_d;
      shreg_q    <= shreg_d;
      config_n   <= config_n_d;
      dclk       <= dclk_d;
      data0      <= data0_d;
      data_ready <= data_ready_d;
      warmres_n  <= warmres_n_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pul_d    = pul_q;
    bit_d    = bit_q;
    hi_d     = hi_q;
    shreg_d  = shreg_q;
    dclk_d   = dclk;
    data0_d  = data0;
    error_d  = error;
    half_end = (cnt_q == HALF_LAST);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_NCFG;
          error_d = 2'b00;
        end
      end
      S_NCFG: begin
        if (cnt_q == NCFG_LAST) state_d = S_WAIT_STATUS;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_WAIT_STATUS: begin
        if (status_n) begin
          state_d = S_LOAD;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
          error_d = 2'b01;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        // A byte offered in the same cycle nSTATUS drops is consumed and discarded.
        if (!status_n) begin
          state_d = S_ERROR;
          error_d = 2'b10;
        end else if (data_valid) begin
          state_d = S_SHIFT;
          shreg_d = data_in;
          data0_d = data_in[0];
          bit_d   = 3'd0;
          hi_d    = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!half_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!hi_q) begin
            hi_d   = 1'b1;
            dclk_d = 1'b1;
          end else if (bit_q != 3'd7) begin
            hi_d    = 1'b0;
            dclk_d  = 1'b0;
            bit_d   = bit_q + 3'd1;
            data0_d = shreg_q[bit_q + 3'd1];
          end else begin
            hi_d   = 1'b0;
            dclk_d = 1'b0;
            if (!status_n) begin
              state_d = S_ERROR;
              error_d = 2'b10;
            end else if (conf_done) begin
              state_d = (EXTRA_DCLK == 0) ? S_WAIT_INIT : S_EXTRA;
              pul_d   = '0;
              data0_d = 1'b0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_EXTRA: begin
        if (!half_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!hi_q) begin
            hi_d   = 1'b1;
            dclk_d = 1'b1;
          end else begin
            hi_d   = 1'b0;
            dclk_d = 1'b0;
            if (pul_q == PUL_LAST) state_d = S_WAIT_INIT;
            else                   pul_d   = pul_q + 1'b1;
          end
        end
      end
      S_WAIT_INIT: begin
        if (init_done) begin
          state_d = S_WRES;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
          error_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRES: begin
        if (cnt_q == WRES_LAST) state_d = S_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Every state entry restarts the shared cycle counter.
    if (state_d != state_q) cnt_d = '0;
    if (state_d != S_SHIFT && state_d != S_EXTRA) dclk_d = 1'b0;

    config_n_d   = (state_d != S_NCFG);
    data_ready_d = (state_d == S_LOAD);
    warmres_n_d  = (state_d != S_WRES);
    done_d       = (state_d == S_DONE);
    busy_d       = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
  end

endmodule
